gate_bist_ctrl: RTL and testbench
=================================

# gate_bist_ctrl

Built-in self-test sequencer for a 2-input logic gate (xor_gate and sibling universal gates). On `start`, it drives the gate inputs through all four vectors {a,b} = 00, 01, 10, 11. It holds each vector for a settle window, samples the gate output and compares it against a programmable 4-bit truth table. It then reports a pass/fail result, a mismatch count and a per-vector failure mask. It sits between the gate under test and a bench or top-level status register.

## Interface
- `HOLD_CYCLES`, default 2: settle cycles per vector before sampling. Must be ≥1. Counter width is $clog2(HOLD_CYCLES+1).
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: request a test run. Accepted only in IDLE.
- `exp_tt` in 4: expected truth table, indexed by {a,b}. XOR = 4'b0110. Latched on start acceptance.
- `gate_c` in 1: output of gate under test.
- `gate_a` out 1: gate input a (registered).
- `gate_b` out 1: gate input b (registered).
- `busy` out 1: high from the cycle after start acceptance through the last SAMPLE cycle.
- `done` out 1: one-cycle pulse when results are valid.
- `pass` out 1: set in the DONE cycle if `err_count`==0. Held until the next start acceptance or reset.
- `err_count` out 3: number of mismatching vectors, 0..4.
- `fail_vec` out 4: bit v set if vector v mismatched.

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE.
- Reset: state=IDLE. All outputs 0: `gate_a`, `gate_b`, `busy`, `done`, `pass`, `err_count`, `fail_vec`. Vector index `vec`=0, hold counter=0.
- IDLE:
  - `gate_a`=`gate_b`=0.
  - On `start`=1: latch `exp_tt`, clear `pass`/`err_count`/`fail_vec`, set `vec`=0, go to DRIVE.
- DRIVE:
  - {`gate_a`,`gate_b`}=`vec`.
  - Count HOLD_CYCLES cycles, then go to SAMPLE.
  - `gate_c` is ignored in DRIVE.
- SAMPLE (1 cycle):
  - Inputs held at `vec`.
  - If `gate_c` != latched `exp_tt[vec]`: set `fail_vec[vec]` and increment `err_count`.
  - If `vec`==3, go to DONE. Otherwise increment `vec`, reset the hold counter and go to DRIVE.
- DONE (1 cycle):
  - `done`=1, `busy`=0, `pass`=(`err_count`==0).
  - `gate_a`=`gate_b`=0.
  - Next state is IDLE.
- `start` in DRIVE, SAMPLE or DONE is ignored; no queuing.
- `exp_tt` changes after acceptance have no effect on the current run.
- `err_count` saturates naturally at 4, since there are only four vectors. No wrap is possible.
- `rst` mid-run: next cycle is IDLE with all outputs cleared, and the run is discarded. `rst` overrides a simultaneous `start`.

## Timing
- Start accepted at edge k. DRIVE begins in cycle k+1.
- Each vector occupies HOLD_CYCLES+1 cycles: HOLD_CYCLES of DRIVE plus 1 of SAMPLE.
- Vector v is driven in cycles k+1+v·(H+1) through k+(v+1)·(H+1).
- `gate_c` is captured at the end of the SAMPLE cycle. The gate path is combinational, so settle time = HOLD_CYCLES+1 edges after the input change.
- `done` is high in cycle k+1+4·(H+1). With H=2, that is cycle k+13.
- `err_count` and `fail_vec` update one cycle after each SAMPLE. They are final when `done`=1.
- Back-to-back runs: the earliest next acceptance is the cycle after DONE. Minimum start-to-start is 4·(H+1)+2 cycles.

## Test plan
- Correct XOR gate, `exp_tt`=0110, H=2, start at k:
  - `gate_a`/`gate_b` read 00,01,10,11, each held for 3 cycles.
  - `done` pulses at k+13 with `pass`=1, `err_count`=0, `fail_vec`=0000.
- `gate_c` stuck at 0, `exp_tt`=0110 -> `pass`=0, `err_count`=2, `fail_vec`=0110.
- XOR gate with `exp_tt`=1001 (XNOR expected) -> `err_count`=4, `fail_vec`=1111, `pass`=0.
- `gate_c` inverted only during DRIVE cycles and correct in SAMPLE cycles -> `pass`=1. Confirms that only sampled cycles count.
- `start` pulsed during DRIVE of vector 1, and again in the DONE cycle -> both ignored. Exactly one `done` pulse at k+13, and `busy` falls with `done`.
- Assert `rst` during vector 2 with an injected error on vector 1:
  - Next cycle: all outputs 0, state IDLE.
  - A fresh start with a correct gate completes 13 cycles later with `pass`=1 and `fail_vec`=0000.

Source files
------------

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer for a 2-input gate: walks {a,b} through 00..11, samples the
// gate output after a settle window and scores it against a truth table.
module gate_bist_ctrl #(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] exp_tt,
  input  logic       gate_c,
  output logic       gate_a,
  output logic       gate_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t        state, state_nx;
  logic [1:0]    vec, vec_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [3:0]    tt, tt_nx;
  logic          pass_nx;
  logic [2:0]    err_nx;
  logic [3:0]    fail_nx;
  logic          gate_a_nx, gate_b_nx, busy_nx, done_nx;

  always_comb begin
    state_nx = state;
    vec_nx   = vec;
    cnt_nx   = cnt;
    tt_nx    = tt;
    pass_nx  = pass;
    err_nx   = err_count;
    fail_nx  = fail_vec;
    case (state)
      IDLE: begin
        if (start) begin
          tt_nx    = exp_tt;
          pass_nx  = 1'b0;
          err_nx   = '0;
          fail_nx  = '0;
          vec_nx   = '0;
          cnt_nx   = '0;
          state_nx = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt == HOLD_LAST) state_nx = SAMPLE;
        else                  cnt_nx   = cnt + CW'(1);
      end
      SAMPLE: begin
        if (gate_c != tt[vec]) begin
          fail_nx[vec] = 1'b1;
          err_nx       = err_count + 3'd1;
        end
        if (vec == 2'd3) begin
          // pass is derived from the post-sample count so it is valid alongside done
          pass_nx  = (err_nx == 3'd0);
          state_nx = DONE;
        end else begin
          vec_nx   = vec + 2'd1;
          cnt_nx   = '0;
          state_nx = DRIVE;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    busy_nx   = (state_nx == DRIVE) || (state_nx == SAMPLE);
    done_nx   = (state_nx == DONE);
    gate_a_nx = busy_nx & vec_nx[1];
    gate_b_nx = busy_nx & vec_nx[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vec       <= '0;
      cnt       <= '0;
      tt        <= '0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
      gate_a    <= 1'b0;
      gate_b    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      vec       <= vec_nx;
      cnt       <= cnt_nx;
      tt        <= tt_nx;
      pass      <= pass_nx;
      err_count <= err_nx;
      fail_vec  <= fail_nx;
      gate_a    <= gate_a_nx;
      gate_b    <= gate_b_nx;
      busy      <= busy_nx;
      done      <= done_nx;
    end
  end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: cycle-indexed run model plus directed scenarios.
module tb_gate_bist_ctrl;

  localparam int H    = 2;
  localparam int LAST = 4 * (H + 1);

  logic       clk = 1'b0;
  logic       rst, start, gate_c;
  logic [3:0] exp_tt;
  logic       gate_a, gate_b, busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;

  int   total = 0;
  int   bad   = 0;
  int   mode  = 0;
  bit   chk_en = 1'b0;
  logic drive_ph = 1'b0;

  // model: m_j = cycle index since acceptance (1..LAST busy, LAST+1 done), 0 = idle
  int         m_j    = 0;
  int         m_err  = 0;
  logic [3:0] m_fail = '0;
  logic [3:0] m_tt   = '0;
  logic       m_pass = 1'b0;

  gate_bist_ctrl #(.HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .start(start), .exp_tt(exp_tt), .gate_c(gate_c),
    .gate_a(gate_a), .gate_b(gate_b), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_vec(fail_vec)
  );

  always #5 clk = ~clk;

  // gate under test emulation
  always_comb begin
    case (mode)
      1:       gate_c = 1'b0;
      2:       gate_c = (gate_a ^ gate_b) ^ drive_ph;
      3:       gate_c = (gate_a ^ gate_b) ^ (~gate_a & gate_b);
      default: gate_c = gate_a ^ gate_b;
    endcase
  end

  function automatic logic gate_fn(input int md, input int v);
    logic [1:0] vv;
    vv = v[1:0];
    case (md)
      1:       return 1'b0;
      3:       return (vv[1] ^ vv[0]) ^ (v == 1);
      default: return vv[1] ^ vv[0];
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_j = 0; m_err = 0; m_fail = '0; m_pass = 1'b0;
    end else if (m_j == 0) begin
      if (start) begin
        m_tt = exp_tt; m_err = 0; m_fail = '0; m_pass = 1'b0; m_j = 1;
      end
    end else begin
      if (m_j <= LAST && (m_j % (H + 1)) == 0) begin
        int v;
        v = (m_j - 1) / (H + 1);
        if (gate_fn(mode, v) != m_tt[v]) begin
          m_fail[v] = 1'b1;
          m_err++;
        end
        if (m_j == LAST) m_pass = (m_err == 0);
      end
      m_j = (m_j == LAST + 1) ? 0 : m_j + 1;
    end
  end

  always @(negedge clk) begin
    logic       b_e;
    logic [1:0] g_e;
    logic [12:0] e, a;
    b_e = (m_j >= 1) && (m_j <= LAST);
    g_e = b_e ? 2'((m_j - 1) / (H + 1)) : 2'b00;
    drive_ph = b_e && ((m_j % (H + 1)) != 0);
    if (chk_en) begin
      e = {g_e, b_e, (m_j == LAST + 1), m_pass, 3'(m_err), m_fail};
      a = {gate_a, gate_b, busy, done, pass, err_count, fail_vec};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL model_cycle j=%0d got=%b want=%b", m_j, a, e);
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // drive one run; returns cycle index of done (or -1) while sitting in that cycle
  task automatic do_run(input int md, input logic [3:0] tt, input bit pokes,
                        output int jdone, output logic [1:0] seq [1:LAST]);
    jdone = -1;
    @(negedge clk);
    mode = md; exp_tt = tt; start = 1'b1;
    @(negedge clk);
    start = 1'b0; exp_tt = ~tt;
    for (int n = 1; n <= 40; n++) begin
      if (done) begin
        jdone = n;
        break;
      end
      if (n <= LAST) seq[n] = {gate_a, gate_b};
      start = (pokes && n == LAST / 4 + H) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    int         jd;
    logic [1:0] seq [1:LAST];
    rst = 1'b1; start = 1'b0; exp_tt = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 16'({gate_a, gate_b, busy, done, pass, err_count, fail_vec}), 16'h0);
    chk_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);

    // correct XOR
    do_run(0, 4'b0110, 1'b0, jd, seq);
    check("xor_done_cycle", 16'(jd), 16'd13);
    check("xor_pass", 16'(pass), 16'd1);
    check("xor_err", 16'(err_count), 16'd0);
    check("xor_fail", 16'(fail_vec), 16'h0);
    check("xor_vec_j1", 16'(seq[1]), 16'd0);
    check("xor_vec_j4", 16'(seq[4]), 16'd1);
    check("xor_vec_j8", 16'(seq[8]), 16'd2);
    check("xor_vec_j12", 16'(seq[12]), 16'd3);
    check("model_pin_xor", 16'(m_err), 16'd0);

    // stuck at 0
    do_run(1, 4'b0110, 1'b0, jd, seq);
    check("stuck_done_cycle", 16'(jd), 16'd13);
    check("stuck_pass", 16'(pass), 16'd0);
    check("stuck_err", 16'(err_count), 16'd2);
    check("stuck_fail", 16'(fail_vec), 16'b0110);
    check("model_pin_stuck", 16'(m_fail), 16'b0110);

    // XNOR expectation against XOR gate
    do_run(0, 4'b1001, 1'b0, jd, seq);
    check("xnor_err", 16'(err_count), 16'd4);
    check("xnor_fail", 16'(fail_vec), 16'b1111);
    check("xnor_pass", 16'(pass), 16'd0);

    // wrong only during DRIVE
    do_run(2, 4'b0110, 1'b0, jd, seq);
    check("drive_glitch_pass", 16'(pass), 16'd1);
    check("drive_glitch_err", 16'(err_count), 16'd0);

    // start pokes mid-run and in DONE
    do_run(0, 4'b0110, 1'b1, jd, seq);
    check("poke_done_cycle", 16'(jd), 16'd13);
    check("poke_busy_at_done", 16'(busy), 16'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("poke_no_rerun", 16'({busy, done}), 16'd0);
      @(negedge clk);
    end

    // reset mid-run during vector 2 with an error injected on vector 1
    mode = 3; exp_tt = 4'b0110; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_rst_err", 16'(err_count), 16'd1);
    check("pre_rst_fail", 16'(fail_vec), 16'b0010);
    check("pre_rst_vec", 16'({gate_a, gate_b}), 16'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_outputs", 16'({gate_a, gate_b, busy, done, pass, err_count, fail_vec}), 16'h0);
    do_run(0, 4'b0110, 1'b0, jd, seq);
    check("fresh_done_cycle", 16'(jd), 16'd13);
    check("fresh_pass", 16'(pass), 16'd1);
    check("fresh_fail", 16'(fail_vec), 16'h0);

    // reset wins over simultaneous start
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_over_start", 16'(busy), 16'd0);
    @(negedge clk);
    check("rst_over_start_2", 16'(busy), 16'd0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
